// File: rtl/move_if.sv
// Signal bundle between the move-input block and its environment: raw switches and
// buttons in, registered position snapshot and move strobes out.
interface move_if;
  logic [8:0] sw_pos;
  logic       btn_x_raw;
  logic       btn_o_raw;
  logic [8:0] sel_pos;
  logic       buttonX;
  logic       buttonO;

  modport slave (
    input  sw_pos,
    input  btn_x_raw,
    input  btn_o_raw,
    output sel_pos,
    output buttonX,
    output buttonO
  );

  modport master (
    output sw_pos,
    output btn_x_raw,
    output btn_o_raw,
    input  sel_pos,
    input  buttonX,
    input  buttonO
  );
endinterface

// File: rtl/move_input.sv
// Synchronizes the position switches and two player buttons, debounces each button and
// emits a one-cycle move strobe together with a snapshot of the switches.
module move_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input logic   clk,
  input logic   reset,
  move_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleaseWait,
    StIdle,
    StPressWait,
    StPressed
  } state_e;

  logic [8:0] sw_meta, sw_s;
  logic [1:0] btn_meta, btn_s;  // [0] = X, [1] = O

  state_e          state_q [2];
  state_e          state_d [2];
  logic [CntW-1:0] cnt_q   [2];
  logic [CntW-1:0] cnt_d   [2];
  logic [1:0]      strobe_d, strobe_q;
  logic [8:0]      sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_s     <= '0;
      btn_meta <= '0;
      btn_s    <= '0;
    end else begin
      sw_meta  <= bus.sw_pos;
      sw_s     <= sw_meta;
      btn_meta <= {bus.btn_o_raw, bus.btn_x_raw};
      btn_s    <= btn_meta;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      strobe_d[i] = 1'b0;
      unique case (state_q[i])
        StReleaseWait: begin
          if (btn_s[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StIdle: begin
          if (btn_s[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = '0;
          end
        end
        StPressWait: begin
          if (!btn_s[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i]  = StPressed;
            cnt_d[i]    = '0;
            strobe_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StPressed: begin
          if (!btn_s[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = StReleaseWait;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Reset wins over a strobe falling due on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StReleaseWait;
        cnt_q[i]   <= '0;
      end
      strobe_q <= '0;
      sel_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      strobe_q <= strobe_d;
      if (|strobe_d) begin
        sel_q <= sw_s;
      end
    end
  end

  assign bus.sel_pos = sel_q;
  assign bus.buttonX = strobe_q[0];
  assign bus.buttonO = strobe_q[1];

endmodule
